// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 display driver: MAX7219 register map,
// SPI core register indices and bit positions, and the controller state encodings.
package max7219_pkg;

    localparam logic [7:0] REG_DIGIT0    = 8'h01;
    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIMIT = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    localparam logic [2:0] SPI_TXDATA  = 3'd1;
    localparam logic [2:0] SPI_STATUS  = 3'd2;
    localparam logic [2:0] SPI_CONTROL = 3'd3;

    localparam int CTRL_SSO = 10;
    localparam int STAT_TMT = 5;

    localparam logic [15:0] CTRL_SS_ON    = 16'(1) << CTRL_SSO;
    localparam logic [15:0] CTRL_SS_OFF   = 16'h0000;
    localparam logic [15:0] STAT_TMT_MASK = 16'(1) << STAT_TMT;

    localparam int INIT_WORDS = 5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SS_ON,
        ST_WAIT_A,
        ST_WR_A,
        ST_WAIT_D,
        ST_WR_D,
        ST_POLL,
        ST_SS_OFF,
        ST_CLR,
        ST_NEXT
    } state_t;

    typedef enum logic [2:0] {
        ACC_IDLE,
        ACC_CYC1,
        ACC_CYC2,
        ACC_GAP,
        ACC_ACK
    } acc_state_t;

    // Power-up command list, sent in index order after every reset.
    function automatic logic [15:0] init_word(
        input logic [3:0] idx,
        input logic [3:0] intensity,
        input logic [2:0] scan_limit
    );
        case (idx)
            4'd0:    return {REG_SHUTDOWN, 8'h01};
            4'd1:    return {REG_DECODE, 8'h00};
            4'd2:    return {REG_INTENSITY, 4'h0, intensity};
            4'd3:    return {REG_SCANLIMIT, 5'h00, scan_limit};
            default: return {REG_TEST, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/spi_avalon_access.sv
// Single Avalon-MM access engine for the SPI core register port: every access is
// exactly two strobe cycles, then an idle cycle, then a one-cycle ack.
module spi_avalon_access
    import max7219_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        spi_select,
    output logic [2:0]  spi_mem_addr,
    output logic        spi_write_n,
    output logic        spi_read_n,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata
);

    acc_state_t  state_reg, state_next;
    logic        we_reg;
    logic [2:0]  addr_reg;
    logic [15:0] wdata_reg;
    logic [15:0] rdata_reg;
    logic        active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ACC_IDLE;
            we_reg    <= 1'b0;
            addr_reg  <= 3'd0;
            wdata_reg <= 16'h0000;
            rdata_reg <= 16'h0000;
        end else begin
            state_reg <= state_next;
            if (state_reg == ACC_IDLE && req) begin
                we_reg    <= we;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
            if (state_reg == ACC_CYC2 && !we_reg) begin
                rdata_reg <= spi_rdata;
            end
        end
    end

    // The ack cycle ignores req so a requester still holding req while it
    // reacts to ack cannot launch a duplicate access.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ACC_IDLE: if (req) state_next = ACC_CYC1;
            ACC_CYC1: state_next = ACC_CYC2;
            ACC_CYC2: state_next = ACC_GAP;
            ACC_GAP:  state_next = ACC_ACK;
            ACC_ACK:  state_next = ACC_IDLE;
            default:  state_next = ACC_IDLE;
        endcase
    end

    assign active       = (state_reg == ACC_CYC1) || (state_reg == ACC_CYC2);
    assign ack          = (state_reg == ACC_ACK);
    assign rdata        = rdata_reg;
    assign spi_select   = active;
    assign spi_mem_addr = active ? addr_reg : 3'd0;
    assign spi_wdata    = (active && we_reg) ? wdata_reg : 16'h0000;
    assign spi_write_n  = !(active && we_reg);
    assign spi_read_n   = !(active && !we_reg);

endmodule

// File: rtl/max7219_spi_driver.sv
// MAX7219 8x8 matrix driver: sends the init list after reset, then refreshes all
// digit rows from a latched frame on request, through the SPI core register port.
module max7219_spi_driver
    import max7219_pkg::*;
#(
    parameter logic [3:0] INTENSITY  = 4'h8,
    parameter logic [2:0] SCAN_LIMIT = 3'd7,
    parameter int         NUM_ROWS   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] frame_rows,
    input  logic        update_req,
    output logic        init_done,
    output logic        busy,
    output logic        done,
    output logic        spi_select,
    output logic [2:0]  spi_mem_addr,
    output logic        spi_write_n,
    output logic        spi_read_n,
    output logic [15:0] spi_wdata,
    input  logic [15:0] spi_rdata,
    input  logic        spi_readyfordata
);

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg, idx_next;
    logic        init_mode_reg, init_mode_next;
    logic [15:0] word_reg, word_next;
    logic [63:0] rows_reg, rows_next;
    logic        pending_reg, pending_next;
    logic        init_done_reg, init_done_next;
    logic        done_reg, done_next;

    logic        acc_req;
    logic        acc_we;
    logic [2:0]  acc_addr;
    logic [15:0] acc_wdata;
    logic        acc_ack;
    logic [15:0] acc_rdata;
    logic        tmt_seen;
    logic [3:0]  last_idx;
    logic [7:0]  row_bytes [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rows
            assign row_bytes[gi] = rows_reg[8*gi +: 8];
        end
    endgenerate

    assign last_idx = init_mode_reg ? 4'(INIT_WORDS - 1) : 4'(NUM_ROWS - 1);
    assign tmt_seen = (acc_rdata & STAT_TMT_MASK) != 16'h0000;

    // Reset lands in LOAD with the init list selected, so init starts on release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_LOAD;
            idx_reg       <= 4'd0;
            init_mode_reg <= 1'b1;
            word_reg      <= 16'h0000;
            rows_reg      <= 64'h0;
            pending_reg   <= 1'b0;
            init_done_reg <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            init_mode_reg <= init_mode_next;
            word_reg      <= word_next;
            rows_reg      <= rows_next;
            pending_reg   <= pending_next;
            init_done_reg <= init_done_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        init_mode_next = init_mode_reg;
        word_next      = word_reg;
        rows_next      = rows_reg;
        pending_next   = pending_reg;
        init_done_next = init_done_reg;
        done_next      = 1'b0;
        acc_req        = 1'b0;
        acc_we         = 1'b1;
        acc_addr       = SPI_CONTROL;
        acc_wdata      = 16'h0000;

        if (update_req && state_reg != ST_IDLE) begin
            pending_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (update_req || pending_reg) begin
                    rows_next      = frame_rows;
                    idx_next       = 4'd0;
                    init_mode_next = 1'b0;
                    pending_next   = 1'b0;
                    state_next     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (init_mode_reg) begin
                    word_next = init_word(idx_reg, INTENSITY, SCAN_LIMIT);
                end else begin
                    word_next = {REG_DIGIT0 + {4'h0, idx_reg}, row_bytes[idx_reg[2:0]]};
                end
                state_next = ST_SS_ON;
            end
            ST_SS_ON: begin
                acc_req   = 1'b1;
                acc_addr  = SPI_CONTROL;
                acc_wdata = CTRL_SS_ON;
                if (acc_ack) state_next = ST_WAIT_A;
            end
            ST_WAIT_A: begin
                if (spi_readyfordata) state_next = ST_WR_A;
            end
            ST_WR_A: begin
                acc_req   = 1'b1;
                acc_addr  = SPI_TXDATA;
                acc_wdata = {8'h00, word_reg[15:8]};
                if (acc_ack) state_next = ST_WAIT_D;
            end
            ST_WAIT_D: begin
                if (spi_readyfordata) state_next = ST_WR_D;
            end
            ST_WR_D: begin
                acc_req   = 1'b1;
                acc_addr  = SPI_TXDATA;
                acc_wdata = {8'h00, word_reg[7:0]};
                if (acc_ack) state_next = ST_POLL;
            end
            ST_POLL: begin
                // Stay here and re-issue the status read until the shifter drains.
                acc_req  = 1'b1;
                acc_we   = 1'b0;
                acc_addr = SPI_STATUS;
                if (acc_ack && tmt_seen) state_next = ST_SS_OFF;
            end
            ST_SS_OFF: begin
                acc_req   = 1'b1;
                acc_addr  = SPI_CONTROL;
                acc_wdata = CTRL_SS_OFF;
                if (acc_ack) state_next = ST_CLR;
            end
            ST_CLR: begin
                acc_req   = 1'b1;
                acc_addr  = SPI_STATUS;
                acc_wdata = 16'h0000;
                if (acc_ack) state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_reg == last_idx) begin
                    state_next = ST_IDLE;
                    if (init_mode_reg) begin
                        init_done_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end else begin
                    idx_next   = idx_reg + 4'd1;
                    state_next = ST_LOAD;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    spi_avalon_access u_access (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (acc_req),
        .we           (acc_we),
        .addr         (acc_addr),
        .wdata        (acc_wdata),
        .ack          (acc_ack),
        .rdata        (acc_rdata),
        .spi_select   (spi_select),
        .spi_mem_addr (spi_mem_addr),
        .spi_write_n  (spi_write_n),
        .spi_read_n   (spi_read_n),
        .spi_wdata    (spi_wdata),
        .spi_rdata    (spi_rdata)
    );

    assign busy      = (state_reg != ST_IDLE);
    assign init_done = init_done_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_max7219_spi_driver.sv
// Bench for max7219_spi_driver: behavioural SPI core + MAX7219 word capture,
// bus-rule monitor, and directed init/refresh/hold/pending/reset scenarios.
module tb_max7219_spi_driver;

    localparam int BYTE_CLKS = 80;

    typedef logic [15:0] wq_t [$];

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] frame_rows = 64'h0;
    logic        update_req = 1'b0;
    logic        init_done, busy, done;
    logic        spi_select, spi_write_n, spi_read_n;
    logic [2:0]  spi_mem_addr;
    logic [15:0] spi_wdata, spi_rdata;
    logic        spi_readyfordata;

    always #10 clk = ~clk;

    max7219_spi_driver dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .frame_rows       (frame_rows),
        .update_req       (update_req),
        .init_done        (init_done),
        .busy             (busy),
        .done             (done),
        .spi_select       (spi_select),
        .spi_mem_addr     (spi_mem_addr),
        .spi_write_n      (spi_write_n),
        .spi_read_n       (spi_read_n),
        .spi_wdata        (spi_wdata),
        .spi_rdata        (spi_rdata),
        .spi_readyfordata (spi_readyfordata)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // SPI core model state
    logic        sso = 1'b0;
    logic        shift_busy = 1'b0;
    logic        hold_full = 1'b0;
    logic [7:0]  shift_byte = 8'h00;
    logic [7:0]  hold_byte = 8'h00;
    int          shift_cnt = 0;
    logic [7:0]  cur_bytes [$];
    logic [15:0] words [$];
    int          bus_err = 0, ss_err = 0, rdy_err = 0, txw_count = 0, done_cnt = 0;
    logic        hold_rdy = 1'b0;

    assign spi_readyfordata = !hold_full && !hold_rdy;
    assign spi_rdata = {9'h000, !hold_full, !shift_busy && !hold_full, 5'h00};

    // Core model and bus monitor, evaluated on the falling edge.
    initial begin : model
        logic strb, idle, rdy_now, prev_strb, prev_idle, prev_wn;
        logic [2:0]  prev_addr;
        logic [15:0] prev_wdata;
        int run_len;
        prev_strb = 1'b0; prev_idle = 1'b1; prev_wn = 1'b1;
        prev_addr = 3'd0; prev_wdata = 16'h0; run_len = 0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!reset_n) begin
                sso = 1'b0; shift_busy = 1'b0; hold_full = 1'b0; shift_cnt = 0;
                cur_bytes.delete();
                run_len = 0; prev_strb = 1'b0; prev_idle = 1'b1;
            end else begin
                rdy_now = spi_readyfordata;
                if (shift_busy) begin
                    shift_cnt--;
                    if (shift_cnt == 0) begin
                        if (!sso) ss_err++;
                        cur_bytes.push_back(shift_byte);
                        if (hold_full) begin
                            shift_byte = hold_byte; hold_full = 1'b0; shift_cnt = BYTE_CLKS;
                        end else begin
                            shift_busy = 1'b0;
                        end
                    end
                end
                strb = spi_select && (!spi_write_n || !spi_read_n);
                idle = !spi_select && spi_write_n && spi_read_n;
                if (!spi_write_n && !spi_read_n) bus_err++;
                if (!spi_select && (!spi_write_n || !spi_read_n)) bus_err++;
                if (spi_select && spi_write_n && spi_read_n) bus_err++;
                if (strb) begin
                    if (prev_strb) begin
                        run_len++;
                        if (spi_mem_addr != prev_addr || spi_wdata != prev_wdata || spi_write_n != prev_wn)
                            bus_err++;
                    end else begin
                        if (!prev_idle) bus_err++;
                        run_len = 1;
                    end
                    if (run_len > 2) bus_err++;
                    if (run_len == 1 && !spi_write_n && spi_mem_addr == 3'd1 && !rdy_now) rdy_err++;
                    if (run_len == 1 && !spi_read_n && spi_mem_addr != 3'd2) bus_err++;
                    if (run_len == 2 && !spi_write_n) begin
                        case (spi_mem_addr)
                            3'd1: begin
                                txw_count++;
                                if (spi_wdata[15:8] != 8'h00) bus_err++;
                                if (!shift_busy) begin
                                    shift_byte = spi_wdata[7:0]; shift_busy = 1'b1; shift_cnt = BYTE_CLKS;
                                end else if (!hold_full) begin
                                    hold_byte = spi_wdata[7:0]; hold_full = 1'b1;
                                end else begin
                                    bus_err++;
                                end
                            end
                            3'd2: if (spi_wdata != 16'h0000) bus_err++;
                            3'd3: begin
                                if (spi_wdata != 16'h0400 && spi_wdata != 16'h0000) bus_err++;
                                if (sso && !spi_wdata[10]) begin
                                    if (shift_busy || hold_full) ss_err++;
                                    if (cur_bytes.size() == 2) begin
                                        words.push_back({cur_bytes[0], cur_bytes[1]});
                                        $display("[TB] word %04h", {cur_bytes[0], cur_bytes[1]});
                                    end else begin
                                        ss_err++;
                                    end
                                end
                                if (spi_wdata[10]) cur_bytes.delete();
                                sso = spi_wdata[10];
                            end
                            default: bus_err++;
                        endcase
                    end
                end else if (prev_strb && run_len != 2) begin
                    bus_err++;
                end
                prev_strb = strb; prev_idle = idle; prev_wn = spi_write_n;
                prev_addr = spi_mem_addr; prev_wdata = spi_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_update();
        @(negedge clk);
        update_req = 1'b1;
        @(negedge clk);
        update_req = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 64'(busy), 64'h0);
    endtask

    task automatic wait_done(input string tag, input int base, input int target, input int budget);
        int n = 0;
        while ((done_cnt - base) < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt - base), 64'(target));
    endtask

    task automatic check_words(input string tag, input int base, input wq_t exp);
        logic [15:0] got;
        check({tag, "_count"}, 64'(words.size() - base), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            got = (base + i < words.size()) ? words[base + i] : 16'hxxxx;
            check($sformatf("%s_w%0d", tag, i), 64'(got), 64'(exp[i]));
        end
    endtask

    task automatic check_rules(input string tag);
        check({tag, "_bus_rules"}, 64'(bus_err), 64'h0);
        check({tag, "_ss_rules"}, 64'(ss_err), 64'h0);
        check({tag, "_rdy_rules"}, 64'(rdy_err), 64'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_select"},    64'(spi_select),   64'h0);
        check({tag, "_addr"},      64'(spi_mem_addr), 64'h0);
        check({tag, "_write_n"},   64'(spi_write_n),  64'h1);
        check({tag, "_read_n"},    64'(spi_read_n),   64'h1);
        check({tag, "_wdata"},     64'(spi_wdata),    64'h0);
        check({tag, "_init_done"}, 64'(init_done),    64'h0);
        check({tag, "_busy"},      64'(busy),         64'h1);
        check({tag, "_done"},      64'(done),         64'h0);
    endtask

    function automatic wq_t rows_words(input logic [63:0] f);
        wq_t q;
        for (int r = 0; r < 8; r++) q.push_back({8'(r + 1), f[8*r +: 8]});
        return q;
    endfunction

    initial begin : main
        wq_t init_q, t2_q, e5, tmp;
        int base, d0, t0, t1, n, lat;
        logic [63:0] fa, fc;
        init_q = '{16'h0C01, 16'h0900, 16'h0A08, 16'h0B07, 16'h0F00};
        t2_q   = '{16'h0181, 16'h0242, 16'h0324, 16'h0418, 16'h0518, 16'h0624, 16'h0742, 16'h0881};

        // Reset state and init sequence
        tick(3);
        check_reset_outputs("rst");
        base = words.size(); d0 = done_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);
        check("init_busy", 64'(busy), 64'h1);
        check("init_done_early", 64'(init_done), 64'h0);
        wait_idle("init", 3000);
        check("init_done_at_idle", 64'(init_done), 64'h1);
        tick(2);
        check_words("init", base, init_q);
        check("init_no_done", 64'(done_cnt - d0), 64'h0);
        check_rules("init");

        // Refresh with a later frame change that must be ignored
        frame_rows = 64'h8142241818244281;
        base = words.size(); d0 = done_cnt;
        pulse_update();
        check("t2_busy", 64'(busy), 64'h1);
        tick(20);
        frame_rows = 64'hFFFF_FFFF_FFFF_FFFF;
        wait_idle("t2", 4000);
        check("t2_done_at_idle", 64'(done), 64'h1);
        tick(2);
        check_words("t2", base, t2_q);
        check("t2_done_count", 64'(done_cnt - d0), 64'h1);
        check_rules("t2");

        // readyfordata held low before the data byte
        frame_rows = 64'h0102040810204080;
        base = words.size(); d0 = done_cnt;
        pulse_update();
        t0 = txw_count; n = 0;
        while (txw_count == t0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t4_first_tx", 64'(txw_count != t0), 64'h1);
        hold_rdy = 1'b1;
        t1 = txw_count;
        tick(500);
        check("t4_hold_nowrite", 64'(txw_count - t1), 64'h0);
        hold_rdy = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(spi_select && !spi_write_n && spi_mem_addr == 3'd1) && lat < 20);
        check("t4_resume_latency", 64'(lat >= 1 && lat <= 3), 64'h1);
        wait_idle("t4", 4000);
        tick(2);
        check_words("t4", base, rows_words(64'h0102040810204080));
        check("t4_done_count", 64'(done_cnt - d0), 64'h1);
        check_rules("t4");

        // Several requests during a refresh collapse into one pending refresh
        fa = 64'h1122334455667788;
        fc = 64'hA5A55A5A3C3CC3C3;
        frame_rows = fa;
        base = words.size(); d0 = done_cnt;
        pulse_update();
        n = 0;
        while ((words.size() - base) < 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        frame_rows = 64'h0F0F0F0F0F0F0F0F;
        pulse_update();
        tick(5);
        pulse_update();
        tick(5);
        pulse_update();
        frame_rows = fc;
        wait_done("t5a", d0, 1, 4000);
        tick(2);
        check("t5_restart_busy", 64'(busy), 64'h1);
        frame_rows = 64'hFFFF0000FFFF0000;
        wait_done("t5b", d0, 2, 4000);
        tick(2);
        check("t5_end_idle", 64'(busy), 64'h0);
        tick(400);
        e5 = rows_words(fa);
        tmp = rows_words(fc);
        foreach (tmp[i]) e5.push_back(tmp[i]);
        check_words("t5", base, e5);
        check("t5_done_count", 64'(done_cnt - d0), 64'h2);
        check("t5_still_idle", 64'(busy), 64'h0);
        check_rules("t5");

        // Reset in the middle of row 4, then full init replay
        frame_rows = 64'h00FF00FF00FF00FF;
        base = words.size();
        pulse_update();
        n = 0;
        while (!((words.size() - base) >= 4 && spi_select) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_row4", 64'(spi_select), 64'h1);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("t6rst");
        tick(3);
        base = words.size(); d0 = done_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        tick(2);
        wait_idle("t6", 3000);
        check("t6_init_done", 64'(init_done), 64'h1);
        tick(2);
        check_words("t6", base, init_q);
        check("t6_no_done", 64'(done_cnt - d0), 64'h0);
        check_rules("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
